btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Front end for the five board push-buttons, feeding the game core's btn[4:0] inputs.
//  - Synchronises and debounces each raw button.
//  - Turns direction presses into queued turn commands, released one per game tick,
//    so presses made between ticks are neither lost nor merged.
//  - Produces a clean, tick-aligned reset request from btn[0].
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  clk cycles a synchronised input must stay stable before the debounced level changes (10 ms @ 100 MHz)
//  QUEUE_DEPTH      2        turn-command queue entries (power of 2, >=2)
//  CNT_W            20       debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  btn_raw    in   5  raw buttons: [0] reset, [1] down, [2] left, [3] right, [4] up
//  tick       in   1  one-clk pulse at each game step (game clock rising edge, resynchronised to clk)
//  btn_out    out  5  to game core btn[4:0]: [0] reset hold, [4:1] one-hot turn for the current step
//  btn_level  out  5  debounced levels, for debug LEDs
//  q_count    out  2  entries currently queued (0..QUEUE_DEPTH)
//  drop_flag  out  1  sticky: a press was dropped because the queue was full; cleared by reset flush
// BEHAVIOUR
//  - Reset (rst=0): every flop clears; btn_out=0, btn_level=0, q_count=0, drop_flag=0.
//  - Sync: two-flop synchroniser per button; 2 clk latency.
//  - Debounce: per-button counter.
//    - Counter clears whenever the synchronised input equals btn_level.
//    - Otherwise it increments; on reaching DEBOUNCE_CYCLES-1, btn_level toggles and the counter clears.
//  - Press event: rising edge of btn_level[k], k=1..4, as a single-cycle pulse.
//    - If several arrive in one cycle, only the highest priority is taken: up > down > left > right.
//  - Direction codes: 0 right, 1 down, 2 left, 3 up.
//  - Push: an accepted press writes its code into the FIFO.
//    - Duplicate filter: the press is discarded when its code equals the last pushed code
//      (the last pushed code is retained after the entry is popped).
//  - Full: a push when q_count==QUEUE_DEPTH with no pop in the same cycle is discarded and sets drop_flag.
//  - Pop: on tick, btn_out[4:1] loads the one-hot of the head entry (bit = code mapped to btn index)
//    and the entry is removed. If the queue is empty, btn_out[4:1] loads 0.
//    btn_out[4:1] holds until the next tick.
//  - Simultaneous tick and push:
//    - Pop first, then push; a push to a full queue succeeds.
//    - On an empty queue the new press is pushed, not popped, this tick.
//  - Reset request: rising edge of btn_level[0] arms a flag.
//    - On the next tick: btn_out[0]=1 for that step; FIFO flushed; last-pushed code cleared to right (0);
//      drop_flag cleared; btn_out[4:1]=0.
//    - btn_out[0] returns to 0 on the following tick unless btn_level[0] is still 1.
//  - Pointers wrap modulo QUEUE_DEPTH; q_count saturates at QUEUE_DEPTH and never underflows.
//  - Asynchronous reset mid-debounce or mid-queue: all state is lost; no pending press survives.
// CONFIGURATION
//  BTN_REVERSE_FILTER_EN
//    - Defined: a press whose code is opposite to the last pushed code (right<->left, up<->down)
//      is discarded at push; drop_flag is not set.
//    - Undefined: such presses are queued; reverse rejection is left to the game core.
// STRUCTURE
//  - Shared package snake_pkg:
//    - DIR_RIGHT/DIR_DOWN/DIR_LEFT/DIR_UP codes
//    - BTN_RST/BTN_DOWN/BTN_LEFT/BTN_RIGHT/BTN_UP indices
//    - function dir_to_onehot
//  - Sub-module btn_debounce: one button's synchroniser and counter, instantiated 5x via generate.
//    The FIFO stays inline.
// TESTING (bench DEBOUNCE_CYCLES=4)
//  1. Bounce btn_raw[2] 0/1 every 2 clk for 20 clk, then hold at 1
//     -> btn_level[2] rises exactly once, 2+4 clk after the stable 1 begins.
//  2. Press up, then left, with no tick; then 2 ticks
//     -> btn_out[4:1]=4'b1000 after the first tick, 4'b0010 after the second; q_count 2->1->0.
//  3. Press right, left, down with no tick (depth 2)
//     -> down dropped; drop_flag=1; q_count=2.
//  4. Press right, release, press right again
//     -> second press filtered; q_count=1.
//  5. tick in the same cycle as a press on an empty queue
//     -> btn_out[4:1]=0 this step; q_count=1; the press is issued at the next tick.
//  6. Queue holding 2 entries, press btn_raw[0], tick
//     -> btn_out=5'b00001; q_count=0; drop_flag=0.
//     With BTN_REVERSE_FILTER_EN defined: right then left -> left discarded, q_count=1.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared codes for the snake button front end: direction codes, button indices
// and the direction-to-button one-hot mapping.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_RIGHT = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_UP    = 2'd3;

    localparam int unsigned BTN_RST   = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_UP    = 4;

    // Returns btn[4:1] with the bit of the button matching the direction set.
    function automatic logic [3:0] dir_to_onehot(input dir_t dir);
        logic [4:0] oh;
        oh = '0;
        unique case (dir)
            DIR_RIGHT: oh[BTN_RIGHT] = 1'b1;
            DIR_DOWN:  oh[BTN_DOWN]  = 1'b1;
            DIR_LEFT:  oh[BTN_LEFT]  = 1'b1;
            DIR_UP:    oh[BTN_UP]    = 1'b1;
            default:   oh = '0;
        endcase
        return oh[4:1];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a stability counter that flips
// the debounced level once the input has differed from it for DEBOUNCE_CYCLES clocks.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: debounce, queue direction presses one per game tick, and
// issue a tick-aligned reset request. Optional macro: BTN_REVERSE_FILTER_EN.
module btn_conditioner
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned QUEUE_DEPTH     = 2,
    parameter int unsigned CNT_W           = 20,
    localparam int unsigned PtrW           = $clog2(QUEUE_DEPTH),
    localparam int unsigned CntW           = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      btn_raw_i,
    input  logic            tick_i,
    output logic [4:0]      btn_out_o,
    output logic [4:0]      btn_level_o,
    output logic [CntW-1:0] q_count_o,
    output logic            drop_flag_o
);

    logic [4:0] level;
    logic [4:0] level_prev_q;
    logic [4:0] rise;

    for (genvar k = 0; k < 5; k++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .raw_i   (btn_raw_i[k]),
            .level_o (level[k])
        );
    end

    assign rise = level & ~level_prev_q;

    dir_t            mem_q [QUEUE_DEPTH];
    dir_t            mem_d [QUEUE_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    dir_t            last_q, last_d;
    logic            last_vld_q, last_vld_d;
    logic            drop_q, drop_d;
    logic            rst_arm_q, rst_arm_d;
    logic            rst_out_q, rst_out_d;
    logic [3:0]      dir_out_q, dir_out_d;

    logic press_vld, dup, rev, accept, flush;
    dir_t press_code;

    always_comb begin
        press_vld  = 1'b1;
        press_code = DIR_RIGHT;
        if (rise[BTN_UP]) begin
            press_code = DIR_UP;
        end else if (rise[BTN_DOWN]) begin
            press_code = DIR_DOWN;
        end else if (rise[BTN_LEFT]) begin
            press_code = DIR_LEFT;
        end else if (rise[BTN_RIGHT]) begin
            press_code = DIR_RIGHT;
        end else begin
            press_vld = 1'b0;
        end
    end

    // An empty history (after reset or flush) filters nothing, so a first right press is kept.
    assign dup = last_vld_q && (press_code == last_q);
`ifdef BTN_REVERSE_FILTER_EN
    assign rev = last_vld_q && (press_code == (last_q ^ 2'b10));
`else
    assign rev = 1'b0;
`endif
    assign flush  = tick_i && rst_arm_q;
    assign accept = press_vld && !dup && !rev && !flush;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        drop_d     = drop_q;
        rst_arm_d  = rst_arm_q | rise[BTN_RST];
        rst_out_d  = rst_out_q;
        dir_out_d  = dir_out_q;

        if (flush) begin
            rst_out_d  = 1'b1;
            dir_out_d  = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            last_d     = DIR_RIGHT;
            last_vld_d = 1'b0;
            drop_d     = 1'b0;
            rst_arm_d  = rise[BTN_RST];
        end else if (tick_i) begin
            rst_out_d = rst_out_q & level[BTN_RST];
            if (count_q != '0) begin
                dir_out_d = dir_to_onehot(mem_q[rd_ptr_q]);
                rd_ptr_d  = rd_ptr_q + 1'b1;
                count_d   = count_q - 1'b1;
            end else begin
                dir_out_d = '0;
            end
        end

        // Push sees the post-pop occupancy, so a full queue accepts on a tick.
        if (accept) begin
            if (count_d == CntW'(QUEUE_DEPTH)) begin
                drop_d = 1'b1;
            end else begin
                mem_d[wr_ptr_q] = press_code;
                wr_ptr_d        = wr_ptr_q + 1'b1;
                count_d         = count_d + 1'b1;
                last_d          = press_code;
                last_vld_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_q[i] <= DIR_RIGHT;
            end
            level_prev_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            last_q       <= DIR_RIGHT;
            last_vld_q   <= 1'b0;
            drop_q       <= 1'b0;
            rst_arm_q    <= 1'b0;
            rst_out_q    <= 1'b0;
            dir_out_q    <= '0;
        end else begin
            mem_q        <= mem_d;
            level_prev_q <= level;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            last_q       <= last_d;
            last_vld_q   <= last_vld_d;
            drop_q       <= drop_d;
            rst_arm_q    <= rst_arm_d;
            rst_out_q    <= rst_out_d;
            dir_out_q    <= dir_out_d;
        end
    end

    assign btn_out_o   = {dir_out_q, rst_out_q};
    assign btn_level_o = level;
    assign q_count_o   = count_q;
    assign drop_flag_o = drop_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a scoreboard of expected turn outputs.
module tb_btn_conditioner;

    localparam int unsigned DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic       tick;
    logic [4:0] btn_out;
    logic [4:0] btn_level;
    logic [1:0] q_count;
    logic       drop_flag;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .QUEUE_DEPTH     (DEPTH),
        .CNT_W           (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .btn_raw_i   (btn_raw),
        .tick_i      (tick),
        .btn_out_o   (btn_out),
        .btn_level_o (btn_level),
        .q_count_o   (q_count),
        .drop_flag_o (drop_flag)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_q[$];
    logic [1:0] m_last;
    bit         m_last_v;
    bit         m_drop;

    int   rise2 = 0;
    logic lvl2_prev = 1'b0;
    always @(negedge clk) begin
        if (btn_level[2] === 1'b1 && lvl2_prev === 1'b0) rise2 <= rise2 + 1;
        lvl2_prev <= btn_level[2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference mapping written out from the button wiring: right=btn3, down=btn1, left=btn2, up=btn4.
    function automatic logic [3:0] onehot(input logic [1:0] c);
        case (c)
            2'd0:    return 4'b0100;
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0010;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic int btn_of(input logic [1:0] c);
        case (c)
            2'd0:    return 3;
            2'd1:    return 1;
            2'd2:    return 2;
            default: return 4;
        endcase
    endfunction

    task automatic model_push(input logic [1:0] c);
        bit rev;
        rev = 1'b0;
`ifdef BTN_REVERSE_FILTER_EN
        rev = m_last_v && (c == (m_last ^ 2'b10));
`endif
        if (m_last_v && c == m_last) begin
        end else if (rev) begin
        end else if (exp_q.size() == DEPTH) begin
            m_drop = 1'b1;
        end else begin
            exp_q.push_back(onehot(c));
            m_last   = c;
            m_last_v = 1'b1;
        end
    endtask

    task automatic wait_level(input int k, input logic val, output int n);
        n = 0;
        while (btn_level[k] !== val && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("level_timeout", {31'b0, btn_level[k]}, {31'b0, val});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        btn_raw = '0;
        tick    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_btn_out", {27'b0, btn_out}, 32'd0);
        check("rst_level", {27'b0, btn_level}, 32'd0);
        check("rst_q_count", {30'b0, q_count}, 32'd0);
        check("rst_drop", {31'b0, drop_flag}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        m_last   = 2'd0;
        m_last_v = 1'b0;
        m_drop   = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [1:0] c);
        int k;
        int n;
        k = btn_of(c);
        @(negedge clk);
        btn_raw[k] = 1'b1;
        wait_level(k, 1'b1, n);
        repeat (2) @(negedge clk);
        btn_raw[k] = 1'b0;
        wait_level(k, 1'b0, n);
        repeat (2) @(negedge clk);
        model_push(c);
        check("press_q_count", {30'b0, q_count}, exp_q.size());
        check("press_drop", {31'b0, drop_flag}, {31'b0, m_drop});
    endtask

    task automatic do_tick(input string tag);
        logic [3:0] e;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        check({tag, "_dir"}, {28'b0, btn_out[4:1]}, {28'b0, e});
        check({tag, "_q_count"}, {30'b0, q_count}, exp_q.size());
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        btn_raw = '0;
        tick    = 1'b0;

        // 1: bounce on left, then a stable press
        do_reset();
        for (int i = 0; i < 10; i++) begin
            btn_raw[2] = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        check("bounce_level_low", {31'b0, btn_level[2]}, 32'd0);
        btn_raw[2] = 1'b1;
        wait_level(2, 1'b1, n);
        check("bounce_latency", n, 32'd6);
        btn_raw[2] = 1'b0;
        wait_level(2, 1'b0, n);
        repeat (2) @(negedge clk);
        check("bounce_rises", rise2, 32'd1);

        // 2: up then left, released on two ticks
        do_reset();
        press(2'd3);
        press(2'd2);
        do_tick("t2_tick1");
        do_tick("t2_tick2");
        do_tick("t2_empty");

        // 3: overfill a depth-2 queue
        do_reset();
`ifdef BTN_REVERSE_FILTER_EN
        press(2'd0);
        press(2'd1);
        press(2'd2);
`else
        press(2'd0);
        press(2'd2);
        press(2'd1);
`endif
        check("t3_drop", {31'b0, drop_flag}, 32'd1);

        // 6: reset request flushes the full queue on the next tick
        @(negedge clk);
        btn_raw[0] = 1'b1;
        wait_level(0, 1'b1, n);
        repeat (2) @(negedge clk);
        btn_raw[0] = 1'b0;
        wait_level(0, 1'b0, n);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        exp_q.delete();
        m_last_v = 1'b0;
        m_drop   = 1'b0;
        check("t6_btn_out", {27'b0, btn_out}, 32'h01);
        check("t6_q_count", {30'b0, q_count}, 32'd0);
        check("t6_drop", {31'b0, drop_flag}, 32'd0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("t6_release", {27'b0, btn_out}, 32'h00);

        // 4: repeated right is filtered
        do_reset();
        press(2'd0);
        press(2'd0);
        do_tick("t4_tick");

        // 5: tick coincides with a press on an empty queue
        do_reset();
        @(negedge clk);
        btn_raw[2] = 1'b1;
        wait_level(2, 1'b1, n);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("t5_dir", {28'b0, btn_out[4:1]}, 32'd0);
        check("t5_q_count", {30'b0, q_count}, 32'd1);
        exp_q.push_back(onehot(2'd2));
        m_last   = 2'd2;
        m_last_v = 1'b1;
        btn_raw[2] = 1'b0;
        wait_level(2, 1'b0, n);
        do_tick("t5_next");

`ifdef BTN_REVERSE_FILTER_EN
        do_reset();
        press(2'd0);
        press(2'd2);
        check("rev_q_count", {30'b0, q_count}, 32'd1);
`endif

        // async reset with entries pending
        do_reset();
        press(2'd3);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
